alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the lab-2 combinational ALU. Accepts one operation at a time over a valid/ready handshake and registers the result and flags. Logic and add/sub ops complete in one cycle; shifts iterate one bit per cycle; an optional shift-add multiplier fills the former reserved opcode 4. Sits between the register-file read stage and writeback of the multi-cycle CPU datapath.

---
 rtl/alu_seq.sv | 174 +++++++++++++++++
 tb/tb_alu_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a valid/ready handshake, iterative one-bit-per-cycle shifts,
// and an optional shift-add multiplier on opcode 4 (enabled by defining ALU_SEQ_MUL_EN).
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [3:0]       op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             equal,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_NOR = 4'd3;
  localparam logic [3:0] OP_MUL = 4'd4;
  localparam logic [3:0] OP_ADD = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SLL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opA_q, opB_q, work_q;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             eq_q;

  logic [WIDTH-1:0] sum, diff, res_d, shift_d, execZ;
  logic             ovf_d, execOvf, execDone, isShift;

  function automatic logic isShiftOp(input logic [3:0] op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
  endfunction

  assign in_ready = (state_q == IDLE);
  assign isShift  = isShiftOp(op_q);

  always_comb begin
    sum   = opA_q + opB_q;
    diff  = opA_q - opB_q;
    res_d = '0;
    ovf_d = 1'b0;
    case (op_q)
      OP_AND: res_d = opA_q & opB_q;
      OP_OR:  res_d = opA_q | opB_q;
      OP_XOR: res_d = opA_q ^ opB_q;
      OP_NOR: res_d = ~(opA_q | opB_q);
      OP_ADD: begin
        res_d = sum;
        ovf_d = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) && (sum[WIDTH-1] != opA_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = diff;
        ovf_d = (opA_q[WIDTH-1] != opB_q[WIDTH-1]) && (diff[WIDTH-1] != opA_q[WIDTH-1]);
      end
      OP_SLT: res_d = WIDTH'($signed(opA_q) < $signed(opB_q));
      default: res_d = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL:  shift_d = {work_q[WIDTH-2:0], 1'b0};
      OP_SRA:  shift_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shift_d = {1'b0, work_q[WIDTH-1:1]};
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // Product register starts as {0, multiplier}; each step adds the multiplicand into the
  // upper half when the LSB is set, then shifts the whole thing right including the carry.
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     mulSum;

  always_comb begin
    mulSum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opA_q} : {(WIDTH+1){1'b0}});
    prod_d = {mulSum, prod_q[WIDTH-1:1]};
  end
`endif

  always_comb begin
    execDone = 1'b1;
    execZ    = res_d;
    execOvf  = ovf_d;
    if (isShift) begin
      execDone = (cnt_q <= CW'(1));
      execZ    = (cnt_q == '0) ? work_q : shift_d;
      execOvf  = 1'b0;
    end
`ifdef ALU_SEQ_MUL_EN
    else if (op_q == OP_MUL) begin
      execDone = (cnt_q == CW'(1));
      execZ    = prod_d[WIDTH-1:0];
      execOvf  = |prod_d[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opA_q     <= '0;
      opB_q     <= '0;
      work_q    <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      eq_q      <= 1'b0;
      Z         <= '0;
      equal     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      prod_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opA_q   <= X;
            opB_q   <= Y;
            op_q    <= op_code;
            work_q  <= X;
            eq_q    <= (X == Y);
            cnt_q   <= isShiftOp(op_code) ? {1'b0, Y[SHW-1:0]} : '0;
`ifdef ALU_SEQ_MUL_EN
            prod_q  <= {{WIDTH{1'b0}}, Y};
            if (op_code == OP_MUL) cnt_q <= CW'(WIDTH);
`endif
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (isShift) work_q <= shift_d;
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
`ifdef ALU_SEQ_MUL_EN
          if (op_q == OP_MUL) prod_q <= prod_d;
`endif
          if (execDone) begin
            Z         <= execZ;
            overflow  <= execOvf;
            zero      <= (execZ == '0);
            equal     <= eq_q;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases, reset mid-shift and random ops checked
// against a plain-arithmetic reference model (honours ALU_SEQ_MUL_EN like the design).
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic         equal, overflow, zero;
  logic [W-1:0] X, Y, Z;
  logic [3:0]   op_code;

  int compared   = 0;
  int mismatched = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .op_code(op_code), .out_valid(out_valid), .out_ready(out_ready),
    .Z(Z), .equal(equal), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: result, overflow and latency straight from the operation rules.
  function automatic void refModel(input logic [3:0] op, input logic [W-1:0] a, b,
                                   output logic [W-1:0] z, output logic ovf, output int lat);
    longint      s;
    logic [63:0] prod;
    logic signed [W-1:0] sa;
    int sh;
    sh  = int'(b[4:0]);
    sa  = a;
    z   = '0;
    ovf = 1'b0;
    lat = 2;
    case (op)
      4'd0: z = a & b;
      4'd1: z = a | b;
      4'd2: z = a ^ b;
      4'd3: z = ~(a | b);
      4'd4: begin
`ifdef ALU_SEQ_MUL_EN
        prod = 64'(a) * 64'(b);
        z    = prod[31:0];
        ovf  = (prod[63:32] != 0);
        lat  = W + 1;
`else
        prod = '0;
        z    = '0;
`endif
      end
      4'd5: begin
        s   = longint'($signed(a)) + longint'($signed(b));
        z   = a + b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: begin
        s   = longint'($signed(a)) - longint'($signed(b));
        z   = a - b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7: z = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: begin z = a >> sh;  lat = 1 + ((sh > 1) ? sh : 1); end
      4'd9: begin z = a << sh;  lat = 1 + ((sh > 1) ? sh : 1); end
      4'd10: begin z = sa >>> sh; lat = 1 + ((sh > 1) ? sh : 1); end
      default: z = '0;
    endcase
  endfunction

  // One full transaction; hold > 0 keeps out_ready low for that many DONE cycles
  // and pulses in_valid once in the middle, which must be ignored.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, b, input int hold);
    logic [W-1:0] expZ;
    logic         expOvf;
    int           expLat, lat, waitCnt;
    refModel(op, a, b, expZ, expOvf, expLat);
    waitCnt = 0;
    while (!in_ready && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("inReadyIdle", in_ready, 1);
    in_valid  = 1'b1;
    X         = a;
    Y         = b;
    op_code   = op;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    X        = $urandom;
    Y        = $urandom;
    op_code  = 4'($urandom);
    checkOutput("inReadyBusy", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checkOutput($sformatf("latency op%0d", op), lat, expLat);
    checkOutput($sformatf("Z op%0d", op), Z, expZ);
    checkOutput($sformatf("overflow op%0d", op), overflow, expOvf);
    checkOutput($sformatf("zero op%0d", op), zero, (expZ == 0));
    checkOutput($sformatf("equal op%0d", op), equal, (a == b));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("holdZ", Z, expZ);
      checkOutput("holdValid", out_valid, 1);
      checkOutput("holdInReady", in_ready, 0);
      in_valid = (i == hold / 2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("validDrop", out_valid, 0);
    checkOutput("readyRise", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [3:0]   op;
    int           seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    X         = '0;
    Y         = '0;
    op_code   = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstZ", Z, 0);
    checkOutput("rstValid", out_valid, 0);
    checkOutput("rstFlags", {equal, overflow, zero}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstInReady", in_ready, 1);

    applyStimulus(4'd5, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    applyStimulus(4'd6, 32'h0000_1234, 32'h0000_1234, 0);
    applyStimulus(4'd7, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    applyStimulus(4'd10, 32'h8000_0000, 32'd31, 0);
    applyStimulus(4'd8, 32'h8000_0000, 32'd31, 0);
    applyStimulus(4'd9, 32'hDEAD_BEEF, 32'h0000_0020, 0);
    applyStimulus(4'd4, 32'h0001_0000, 32'h0001_0000, 0);
    applyStimulus(4'd4, 32'd7, 32'd6, 2);
    applyStimulus(4'd12, 32'h5555_AAAA, 32'h5555_AAAA, 0);
    applyStimulus(4'd3, 32'h0F0F_0000, 32'h0000_F0F0, 10);

    // Reset while an SLL by 20 is still shifting: nothing may come out afterwards.
    in_valid = 1'b1;
    X        = 32'd1;
    Y        = 32'd20;
    op_code  = 4'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstZ", Z, 0);
    checkOutput("midRstValid", out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midRstInReady", in_ready, 1);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("midRstNoResult", seen, 0);

    for (int n = 0; n < 80; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if (op == 4'd4 && $urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, 65535);
        b = $urandom_range(0, 65535);
      end
      applyStimulus(op, a, b, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
